irq_coalesce_ctrl: RTL and testbench
====================================

// Module: irq_coalesce_ctrl
// PURPOSE
//  Parametrised interrupt controller with sticky W1C status, per-source edge/level capture
//  and interrupt coalescing. irq is held off until enough events accumulate or a timeout expires.
//  Sits between MAC/DMA event sources and the AXI-Lite CSR block; CSR drives enable/mode/w1c/thresholds.
// PARAMETERS
//  NUM    8   number of interrupt sources (1..32)
//  CNT_W  8   width of coalescing event counter / threshold
//  TMR_W  16  width of coalescing timer / timeout (clk cycles)
// PORTS
//  clk           in   1      single clock domain
//  rst_n         in   1      asynchronous, active-low reset
//  event_in      in   NUM    raw event inputs (pulse or level)
//  mode_level    in   NUM    per-source: 1=level-sensitive, 0=rising-edge
//  enable        in   NUM    mask; only enabled bits feed coalescing and irq
//  w1c           in   NUM    1-cycle software clear strobe per bit
//  coal_thresh   in   CNT_W  event count that fires irq; 0 or 1 = no coalescing
//  coal_timeout  in   TMR_W  cycles in ARMED before forced fire; 0 = timer disabled
//  status        out  NUM    sticky pending bits
//  evt_count     out  CNT_W  enabled-event counter since last IDLE (saturating)
//  irq           out  1      coalesced interrupt, registered
// BEHAVIOUR
//  Reset: status=0, event_d=0, evt_count=0, timer=0, state=IDLE, irq=0 (irq_id=0 if built).
//  Capture: set[i] = mode_level[i] ? event_in[i] : (event_in[i] & ~event_d[i]); event_d <= event_in.
//  status[i] <= set[i] | (status[i] & ~w1c[i]); set and w1c same cycle -> set wins, bit stays 1.
//  Level source held high cannot be cleared; w1c takes effect the cycle after the level drops.
//  Event at edge N -> status visible N+1. Mask changes never alter status.
//  masked = status & enable. new_evt = |(set & enable & ~status) (first set of a bit only).
//  evt_count: +1 per cycle in which new_evt=1, saturates at all-ones, cleared on entering IDLE.
//  FSM (irq_pkg::irq_state_e):
//   IDLE : irq=0, timer=0, count=0. masked!=0 -> FIRE if coal_thresh<=1, else ARMED.
//   ARMED: timer +1 per cycle (saturating). masked==0 -> IDLE (priority);
//          evt_count>=coal_thresh, or (coal_timeout!=0 && timer>=coal_timeout-1) -> FIRE.
//   FIRE : irq=1 (registered with state). Stays until masked==0 -> IDLE next cycle.
//  New events during FIRE keep irq high; no re-arm until all enabled bits cleared.
//  Latency with coal_thresh<=1: event edge N -> status N+1 -> irq N+2.
//  Threshold/timeout sampled live; lowering coal_thresh in ARMED can fire next cycle.
//  Async reset mid-ARMED/FIRE: all state returns to reset values immediately; no spurious irq.
//  Width rules: evt_count and timer compare unsigned, CNT_W / TMR_W bits, no wrap (saturate).
// CONFIGURATION
//  IRQ_CAUSE_EN defined: adds output irq_id [$clog2(NUM)-1:0] = index of lowest set bit of
//   masked, registered (valid one cycle after status); 0 when masked==0.
//  IRQ_CAUSE_EN undefined: irq_id port and priority encoder absent; all else identical.
// STRUCTURE
//  irq_pkg: irq_state_e {IDLE, ARMED, FIRE}, IRQ_MAX_NUM=32, clog2 helper for irq_id width.
//  Sub-module irq_prio_enc (param N; lowest-index-wins encoder), instantiated only under IRQ_CAUSE_EN.
//  Top holds capture, status, counter, timer and FSM.
// TESTING
//  1 thresh=1, timeout=0, enable=0x01, edge pulse src0 @N -> status=0x01 @N+1, irq=1 @N+2; w1c=0x01 -> irq=0 two cycles later.
//  2 thresh=3, timeout=0, enable=0xFF, edge pulses src0,src1,src2 in separate cycles -> irq stays 0 until evt_count=3, then 1 next cycle.
//  3 thresh=10, timeout=20, single event -> irq rises exactly 20 cycles after ARMED entry; evt_count=1.
//  4 level src3 held high, w1c=0x08 repeatedly -> status[3] stays 1; drop level, w1c -> status[3]=0, irq=0.
//  5 pulse src2 and w1c=0x04 same cycle -> status[2]=1; enable=0 during ARMED -> IDLE, irq never asserts.
//  6 assert rst_n=0 while FIRE -> irq, status, evt_count 0 immediately; IRQ_CAUSE_EN: src5+src2 pending -> irq_id=2.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the interrupt coalescing controller.
// Used by irq_coalesce_ctrl and, when IRQ_CAUSE_EN is defined, irq_prio_enc.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } irq_state_e;

  localparam int IRQ_MAX_NUM = 32;

  // irq_id width; never zero so a single-source build still has a legal port.
  function automatic int irq_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder; returns 0 when nothing is requested.
// Only instantiated when IRQ_CAUSE_EN is defined.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]             i_req,
  output logic [irq_id_w(N)-1:0]   o_idx
);

  localparam int W = irq_id_w(N);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_coalesce_ctrl.sv
// irq_coalesce_ctrl: sticky W1C interrupt status with edge/level capture and coalescing FSM.
// Define IRQ_CAUSE_EN to add the registered irq_id output (lowest pending enabled source).
module irq_coalesce_ctrl
  import irq_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM-1:0]            event_in,
  input  logic [NUM-1:0]            mode_level,
  input  logic [NUM-1:0]            enable,
  input  logic [NUM-1:0]            w1c,
  input  logic [CNT_W-1:0]          coal_thresh,
  input  logic [TMR_W-1:0]          coal_timeout,
  output logic [NUM-1:0]            status,
  output logic [CNT_W-1:0]          evt_count,
`ifdef IRQ_CAUSE_EN
  output logic [irq_id_w(NUM)-1:0]  irq_id,
`endif
  output logic                      irq
);

  logic [NUM-1:0]   r_event_d;
  logic [NUM-1:0]   r_status;
  logic [CNT_W-1:0] r_count;
  logic [TMR_W-1:0] r_timer;
  irq_state_e       r_state;
  logic             r_irq;

  logic [NUM-1:0]   w_set;
  logic [NUM-1:0]   w_masked;
  logic             w_new_evt;
  logic             w_count_inc;
  logic             w_timeout_hit;
  logic             w_fire;

  assign w_set       = (mode_level & event_in) | (~mode_level & event_in & ~r_event_d);
  assign w_masked    = r_status & enable;
  // Only the first set of an enabled bit counts; re-hits on a pending bit are ignored.
  assign w_new_evt   = |(w_set & enable & ~r_status);
  assign w_count_inc = w_new_evt && !(&r_count);

  assign w_timeout_hit = (coal_timeout != '0) && (r_timer >= (coal_timeout - TMR_W'(1)));
  assign w_fire        = (r_count >= coal_thresh) || w_timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event_d <= '0;
      r_status  <= '0;
    end else begin
      r_event_d <= event_in;
      r_status  <= w_set | (r_status & ~w1c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_count <= '0;
      r_timer <= '0;
    end else begin
      if (w_count_inc) r_count <= r_count + CNT_W'(1);
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_masked != '0) begin
            if (coal_thresh <= CNT_W'(1)) begin
              r_state <= FIRE;
              r_irq   <= 1'b1;
            end else begin
              r_state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (!(&r_timer)) r_timer <= r_timer + TMR_W'(1);
          // Losing every enabled pending bit takes priority over firing.
          if (w_masked == '0) begin
            r_state <= IDLE;
            r_count <= '0;
            r_timer <= '0;
          end else if (w_fire) begin
            r_state <= FIRE;
            r_irq   <= 1'b1;
            r_timer <= '0;
          end
        end
        FIRE: begin
          r_timer <= '0;
          if (w_masked == '0) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
          r_count <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign status    = r_status;
  assign evt_count = r_count;
  assign irq       = r_irq;

`ifdef IRQ_CAUSE_EN
  logic [irq_id_w(NUM)-1:0] w_idx;
  logic [irq_id_w(NUM)-1:0] r_irq_id;

  irq_prio_enc #(.N(NUM)) u_prio_enc (
    .i_req (w_masked),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_id <= '0;
    else        r_irq_id <= w_idx;
  end

  assign irq_id = r_irq_id;
`endif

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
// tb_irq_coalesce_ctrl: directed self-checking bench for irq_coalesce_ctrl (NUM=8, CNT_W=8, TMR_W=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_irq_coalesce_ctrl;

  localparam int NUM   = 8;
  localparam int CNT_W = 8;
  localparam int TMR_W = 16;

  logic             clk;
  logic             rst_n;
  logic [NUM-1:0]   event_in;
  logic [NUM-1:0]   mode_level;
  logic [NUM-1:0]   enable;
  logic [NUM-1:0]   w1c;
  logic [CNT_W-1:0] coal_thresh;
  logic [TMR_W-1:0] coal_timeout;
  logic [NUM-1:0]   status;
  logic [CNT_W-1:0] evt_count;
  logic             irq;
`ifdef IRQ_CAUSE_EN
  logic [2:0]       irq_id;
`endif

  int n_checks = 0;
  int n_errors = 0;

  irq_coalesce_ctrl #(.NUM(NUM), .CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .event_in     (event_in),
    .mode_level   (mode_level),
    .enable       (enable),
    .w1c          (w1c),
    .coal_thresh  (coal_thresh),
    .coal_timeout (coal_timeout),
    .status       (status),
    .evt_count    (evt_count),
`ifdef IRQ_CAUSE_EN
    .irq_id       (irq_id),
`endif
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    event_in     = '0;
    mode_level   = '0;
    enable       = '0;
    w1c          = '0;
    coal_thresh  = 8'd1;
    coal_timeout = 16'd0;
    repeat (3) tick();
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_count", 32'(evt_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: immediate fire, edge source 0
    enable   = 8'h01;
    event_in = 8'h01;
    tick();
    chk("t1_status", 32'(status), 32'h01);
    chk("t1_irq_n1", 32'(irq), 32'h0);
    event_in = 8'h00;
    tick();
    chk("t1_irq_n2", 32'(irq), 32'h1);
    chk("t1_count", 32'(evt_count), 32'h1);
    w1c = 8'h01;
    tick();
    w1c = 8'h00;
    chk("t1_clr_status", 32'(status), 32'h0);
    chk("t1_irq_hold", 32'(irq), 32'h1);
    tick();
    chk("t1_irq_drop", 32'(irq), 32'h0);
    chk("t1_count_idle", 32'(evt_count), 32'h0);

    // 2: threshold of three distinct edge events
    coal_thresh = 8'd3;
    enable      = 8'hFF;
    event_in    = 8'h01;
    tick();
    event_in = 8'h02;
    tick();
    chk("t2_irq_e2", 32'(irq), 32'h0);
    event_in = 8'h04;
    tick();
    event_in = 8'h00;
    chk("t2_count3", 32'(evt_count), 32'h3);
    chk("t2_irq_e3", 32'(irq), 32'h0);
    tick();
    chk("t2_irq_fire", 32'(irq), 32'h1);
    w1c = 8'hFF;
    tick();
    w1c = 8'h00;
    tick();
    chk("t2_irq_clr", 32'(irq), 32'h0);
    chk("t2_count_clr", 32'(evt_count), 32'h0);

    // 3: timeout fire 20 cycles after ARMED entry; repeat hit on a pending bit is not counted
    coal_thresh  = 8'd10;
    coal_timeout = 16'd20;
    event_in     = 8'h01;
    tick();
    event_in = 8'h00;
    tick();
    for (int i = 1; i <= 19; i++) begin
      event_in = (i == 5) ? 8'h01 : 8'h00;
      tick();
    end
    event_in = 8'h00;
    chk("t3_irq_19", 32'(irq), 32'h0);
    tick();
    chk("t3_irq_20", 32'(irq), 32'h1);
    chk("t3_count", 32'(evt_count), 32'h1);
    coal_timeout = 16'd0;
    w1c = 8'hFF;
    tick();
    w1c = 8'h00;
    tick();
    chk("t3_irq_clr", 32'(irq), 32'h0);

    // 4: level source 3 cannot be cleared while high
    coal_thresh = 8'd1;
    mode_level  = 8'h08;
    enable      = 8'h08;
    event_in    = 8'h08;
    tick();
    w1c = 8'h08;
    tick();
    chk("t4_status_held1", 32'(status), 32'h08);
    tick();
    chk("t4_status_held2", 32'(status), 32'h08);
    chk("t4_irq_on", 32'(irq), 32'h1);
    w1c      = 8'h00;
    event_in = 8'h00;
    tick();
    chk("t4_status_sticky", 32'(status), 32'h08);
    w1c = 8'h08;
    tick();
    w1c = 8'h00;
    chk("t4_status_clr", 32'(status), 32'h0);
    tick();
    chk("t4_irq_off", 32'(irq), 32'h0);
    mode_level = 8'h00;

    // 5: set beats w1c; disabling during ARMED returns to IDLE without irq
    coal_thresh = 8'd3;
    enable      = 8'hFF;
    event_in    = 8'h04;
    w1c         = 8'h04;
    tick();
    event_in = 8'h00;
    w1c      = 8'h00;
    chk("t5_set_wins", 32'(status), 32'h04);
    tick();
    enable = 8'h00;
    tick();
    chk("t5_irq_armed", 32'(irq), 32'h0);
    tick();
    chk("t5_count_idle", 32'(evt_count), 32'h0);
    chk("t5_status_mask", 32'(status), 32'h04);
    chk("t5_irq_never", 32'(irq), 32'h0);
    w1c = 8'h04;
    tick();
    w1c    = 8'h00;
    enable = 8'hFF;
    tick();

    // 7: lowering the threshold while ARMED fires on the next edge
    coal_thresh = 8'd5;
    event_in    = 8'h02;
    tick();
    event_in = 8'h00;
    tick();
    tick();
    chk("t7_irq_armed", 32'(irq), 32'h0);
    coal_thresh = 8'd1;
    tick();
    chk("t7_irq_live", 32'(irq), 32'h1);
    w1c = 8'hFF;
    tick();
    w1c = 8'h00;
    tick();

    // 6: asynchronous reset while FIRE
    coal_thresh = 8'd1;
    event_in    = 8'h24;
    tick();
    event_in = 8'h00;
    tick();
    chk("t6_irq_fire", 32'(irq), 32'h1);
    chk("t6_count2", 32'(evt_count), 32'h1);
`ifdef IRQ_CAUSE_EN
    chk("t6_irq_id", 32'(irq_id), 32'h2);
`endif
    rst_n = 1'b0;
    #1;
    chk("t6_rst_irq", 32'(irq), 32'h0);
    chk("t6_rst_status", 32'(status), 32'h0);
    chk("t6_rst_count", 32'(evt_count), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_no_spurious", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
